// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bundle of load_store_unit.
// slave = the unit itself; master = execute stage plus memory around it.
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] mem_rd;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wd
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wd
  );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory initiator: RV32I loads, direct word stores, read-modify-write byte/half stores.
// Build option: define MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    RMW_WR = 3'd3,
    WRITE  = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t                state_q, state_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [15:0]           hword_q, hword_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wd_q, mem_wd_d;
  logic [DATA_WIDTH-1:0] merge_q, merge_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  mem_we_q, mem_we_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic                  accept_s;
  logic                  illegal_s;
  logic                  misalign_s;

  function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    if (we) begin
      bad = (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W);
    end else begin
      bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    return bad;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] f3,
                                                        input logic [DATA_WIDTH-1:0] rd);
    logic [DATA_WIDTH-1:0] ext;
    case (f3)
      F3_B:    ext = {{(DATA_WIDTH-8){rd[7]}}, rd[7:0]};
      F3_H:    ext = {{(DATA_WIDTH-16){rd[15]}}, rd[15:0]};
      F3_BU:   ext = {{(DATA_WIDTH-8){1'b0}}, rd[7:0]};
      F3_HU:   ext = {{(DATA_WIDTH-16){1'b0}}, rd[15:0]};
      default: ext = rd;
    endcase
    return ext;
  endfunction

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign accept_s      = bus.req_valid && bus.req_ready;
  assign illegal_s     = funct3_illegal(bus.req_we, bus.req_funct3);

`ifdef MISALIGN_TRAP_EN
  // funct3[1:0] is 01 for LH/LHU/SH and 10 for LW/SW; the illegal codes sharing those bits are already rejected
  assign misalign_s = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  // Next-state and registered-output logic of the access sequencer.
  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    hword_d      = hword_q;
    mem_addr_d   = mem_addr_q;
    mem_wd_d     = mem_wd_q;
    merge_d      = merge_q;
    mem_we_d     = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          funct3_d = bus.req_funct3;
          hword_d  = bus.req_wdata[15:0];
          if (illegal_s || misalign_s) begin
            state_d = ERR;
          end else begin
            mem_addr_d = bus.req_addr;
            if (!bus.req_we) begin
              state_d = LOAD;
            end else if (bus.req_funct3 == F3_W) begin
              state_d  = WRITE;
              mem_we_d = 1'b1;
              mem_wd_d = bus.req_wdata;
            end else begin
              state_d = RMW_RD;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = load_extend(funct3_q, bus.mem_rd);
        state_d      = IDLE;
      end
      RMW_RD: begin
        // funct3[0] separates SH from SB
        if (funct3_q[0]) begin
          merge_d = {bus.mem_rd[DATA_WIDTH-1:16], hword_q};
        end else begin
          merge_d = {bus.mem_rd[DATA_WIDTH-1:8], hword_q[7:0]};
        end
        mem_wd_d = merge_d;
        mem_we_d = 1'b1;
        state_d  = RMW_WR;
      end
      RMW_WR, WRITE: begin
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      ERR: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      funct3_q     <= 3'b000;
      hword_q      <= 16'h0000;
      mem_addr_q   <= '0;
      mem_wd_q     <= '0;
      merge_q      <= '0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      hword_q      <= hword_d;
      mem_addr_q   <= mem_addr_d;
      mem_wd_q     <= mem_wd_d;
      merge_q      <= merge_d;
      mem_we_q     <= mem_we_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wd     = mem_wd_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/back-to-back sequences,
// then random accesses checked against a byte-array reference model.
module tb_load_store_unit;
  localparam int AW        = 17;
  localparam int DW        = 32;
  localparam int MEM_BYTES = 1 << AW;

  typedef struct {
    logic          we;
    logic [2:0]    f3;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
    int            exp_lat;
    int            exp_nwe;
    logic [DW-1:0] exp_wd;
  } vec_t;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          clr_mem = 1'b1;
  logic          bd_we   = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  int            n_cmp   = 0;
  int            n_fail  = 0;
  logic [7:0]    mem_b [MEM_BYTES];
  logic [7:0]    ref_b [MEM_BYTES];

  always #5 clk = ~clk;

  load_store_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  load_store_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Memory array: asynchronous 4-byte read with address wrap.
  always_comb begin
    for (int i = 0; i < 4; i++) bus.mem_rd[8*i +: 8] = mem_b[bus.mem_addr + AW'(i)];
  end

  // Memory array: clear, DUT full-word write, bench preload.
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < MEM_BYTES; i++) mem_b[AW'(i)] <= 8'h00;
    end else if (bus.mem_we) begin
      for (int i = 0; i < 4; i++) mem_b[bus.mem_addr + AW'(i)] <= bus.mem_wd[8*i +: 8];
    end else if (bd_we) begin
      for (int i = 0; i < 4; i++) mem_b[bd_addr + AW'(i)] <= bd_data[8*i +: 8];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_b[a + AW'(i)];
    return w;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    for (int i = 0; i < 4; i++) ref_b[a + AW'(i)] = d[8*i +: 8];
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Reference: byte-level effect and expected response of one access.
  task automatic model_op(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, output logic [DW-1:0] e_rd,
                          output logic e_err, output int e_lat, output int e_nwe,
                          output logic [DW-1:0] e_wd);
    int            size;
    logic          legal;
    logic [DW-1:0] w;
    legal = we ? (f3 <= 3'd2) : ((f3 <= 3'd5) && (f3 != 3'd3));
    size  = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
`ifdef MISALIGN_TRAP_EN
    if (legal && ((int'(a) % size) != 0)) legal = 1'b0;
`endif
    e_rd  = '0;
    e_err = 1'b0;
    e_lat = 2;
    e_nwe = 0;
    e_wd  = '0;
    if (!legal) begin
      e_err = 1'b1;
    end else if (!we) begin
      w = ref_word(a);
      case (f3)
        3'd0:    e_rd = {{24{w[7]}}, w[7:0]};
        3'd1:    e_rd = {{16{w[15]}}, w[15:0]};
        3'd4:    e_rd = {24'h000000, w[7:0]};
        3'd5:    e_rd = {16'h0000, w[15:0]};
        default: e_rd = w;
      endcase
    end else begin
      for (int i = 0; i < size; i++) ref_b[a + AW'(i)] = wd[8*i +: 8];
      e_lat = (size == 4) ? 2 : 3;
      e_nwe = 1;
      e_wd  = ref_word(a);
    end
  endtask

  // Issue one request from a negedge; returns at the negedge of the response cycle.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, output logic [DW-1:0] rd, output logic err,
                       output int lat, output int nwe, output logic [DW-1:0] mwd,
                       output int waited);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    waited = 0;
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom_range(0, 1));
    bus.req_funct3 = 3'($urandom_range(0, 7));
    bus.req_addr   = AW'($urandom);
    bus.req_wdata  = $urandom;
    lat = 1;
    nwe = 0;
    mwd = '0;
    while (!bus.resp_valid && lat < 12) begin
      if (bus.mem_we) begin
        nwe++;
        mwd = bus.mem_wd;
      end
      @(negedge clk);
      lat++;
    end
    rd  = bus.resp_rdata;
    err = bus.resp_err;
  endtask

  initial begin : main
    vec_t          vecs [18];
    logic [DW-1:0] rd, e_rd, mwd, e_wd;
    logic          err, e_err;
    int            lat, e_lat, nwe, e_nwe, waited, we_seen, rv_seen;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    for (int i = 0; i < MEM_BYTES; i++) ref_b[AW'(i)] = 8'h00;
    repeat (2) @(negedge clk);
    clr_mem = 1'b0;

    chk("reset req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("reset resp_rdata", bus.resp_rdata, 32'd0);
    chk("reset resp_err", 32'(bus.resp_err), 32'd0);
    chk("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("reset mem_we", 32'(bus.mem_we), 32'd0);
    chk("reset mem_wd", bus.mem_wd, 32'd0);

    preload(17'h00100, 32'h11223384);
    preload(17'h00104, 32'h0000005A);
    preload(17'h00200, 32'hAABBCCDD);
    preload(17'h00204, 32'h00000000);
    preload(17'h00300, 32'h11111111);
    rst = 1'b0;
    @(negedge clk);
    chk("ready after reset", 32'(bus.req_ready), 32'd1);

    vecs[0]  = '{1'b0, 3'b000, 17'h00100, 32'h0,        32'hFFFFFF84, 1'b0, 2, 0, 32'h0};
    vecs[1]  = '{1'b0, 3'b100, 17'h00100, 32'h0,        32'h00000084, 1'b0, 2, 0, 32'h0};
    vecs[2]  = '{1'b0, 3'b010, 17'h00100, 32'h0,        32'h11223384, 1'b0, 2, 0, 32'h0};
    vecs[3]  = '{1'b0, 3'b001, 17'h00100, 32'h0,        32'h00003384, 1'b0, 2, 0, 32'h0};
    vecs[4]  = '{1'b1, 3'b000, 17'h00200, 32'h00000055, 32'h0,        1'b0, 3, 1, 32'hAABBCC55};
    vecs[5]  = '{1'b0, 3'b010, 17'h00200, 32'h0,        32'hAABBCC55, 1'b0, 2, 0, 32'h0};
    vecs[6]  = '{1'b1, 3'b001, 17'h00202, 32'hFFFF1234, 32'h0,        1'b0, 3, 1, 32'h00001234};
    vecs[7]  = '{1'b0, 3'b101, 17'h00202, 32'h0,        32'h00001234, 1'b0, 2, 0, 32'h0};
    vecs[8]  = '{1'b1, 3'b001, 17'h00202, 32'h0000BEEF, 32'h0,        1'b0, 3, 1, 32'h0000BEEF};
    vecs[9]  = '{1'b0, 3'b001, 17'h00202, 32'h0,        32'hFFFFBEEF, 1'b0, 2, 0, 32'h0};
    vecs[10] = '{1'b0, 3'b111, 17'h00100, 32'h0,        32'h0,        1'b1, 2, 0, 32'h0};
`ifdef MISALIGN_TRAP_EN
    vecs[11] = '{1'b0, 3'b010, 17'h00101, 32'h0,        32'h0,        1'b1, 2, 0, 32'h0};
`else
    vecs[11] = '{1'b0, 3'b010, 17'h00101, 32'h0,        32'h5A112233, 1'b0, 2, 0, 32'h0};
`endif
    vecs[12] = '{1'b1, 3'b010, 17'h00010, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF};
    vecs[13] = '{1'b0, 3'b010, 17'h00010, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'h0};
    vecs[14] = '{1'b1, 3'b011, 17'h00020, 32'h12345678, 32'h0,        1'b1, 2, 0, 32'h0};
    vecs[15] = '{1'b0, 3'b010, 17'h00200, 32'h0,        32'hBEEFCC55, 1'b0, 2, 0, 32'h0};
    vecs[16] = '{1'b1, 3'b000, 17'h1FFFF, 32'h123456AB, 32'h0,        1'b0, 3, 1, 32'h000000AB};
    vecs[17] = '{1'b0, 3'b010, 17'h1FFFC, 32'h0,        32'hAB000000, 1'b0, 2, 0, 32'h0};

    for (int i = 0; i < 18; i++) begin
      model_op(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, e_rd, e_err, e_lat, e_nwe, e_wd);
      issue(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, err, lat, nwe, mwd, waited);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d mem_we cycles", i), 32'(nwe), 32'(vecs[i].exp_nwe));
      if (vecs[i].exp_nwe > 0) chk($sformatf("vec%0d mem_wd", i), mwd, vecs[i].exp_wd);
    end

    // Reset sampled at the edge that ends RMW_RD of SB 0x300.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 17'h00300;
    bus.req_wdata  = 32'h00000077;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    chk("rst ready low", 32'(bus.req_ready), 32'd0);
    we_seen = int'(bus.mem_we);
    rv_seen = int'(bus.resp_valid);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      we_seen += int'(bus.mem_we);
      rv_seen += int'(bus.resp_valid);
      @(negedge clk);
    end
    chk("rst ready after release", 32'(bus.req_ready), 32'd1);
    chk("rst no mem_we", 32'(we_seen), 32'd0);
    chk("rst no resp_valid", 32'(rv_seen), 32'd0);
    issue(1'b0, 3'b010, 17'h00300, 32'h0, rd, err, lat, nwe, mwd, waited);
    chk("rst mem unchanged", rd, 32'h11111111);

    // Back-to-back loads: second issued in the first one's response cycle.
    issue(1'b0, 3'b010, 17'h00100, 32'h0, rd, err, lat, nwe, mwd, waited);
    chk("b2b first rdata", rd, 32'h11223384);
    model_op(1'b0, 3'b010, 17'h00200, 32'h0, e_rd, e_err, e_lat, e_nwe, e_wd);
    issue(1'b0, 3'b010, 17'h00200, 32'h0, rd, err, lat, nwe, mwd, waited);
    chk("b2b accepted at once", 32'(waited), 32'd0);
    chk("b2b second latency", 32'(lat), 32'd2);
    chk("b2b second rdata", rd, e_rd);
    @(negedge clk);
    chk("resp_valid single pulse", 32'(bus.resp_valid), 32'd0);

    for (int k = 0; k < 300; k++) begin
      logic          we_r;
      logic [2:0]    f3_r;
      logic [AW-1:0] a_r;
      logic [DW-1:0] wd_r;
      we_r = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        f3_r = 3'($urandom_range(0, 7));
      end else if (we_r) begin
        f3_r = 3'($urandom_range(0, 2));
      end else begin
        case ($urandom_range(0, 4))
          0:       f3_r = 3'd0;
          1:       f3_r = 3'd1;
          2:       f3_r = 3'd2;
          3:       f3_r = 3'd4;
          default: f3_r = 3'd5;
        endcase
      end
      case ($urandom_range(0, 2))
        0:       a_r = 17'h00400 + AW'($urandom_range(0, 15));
        1:       a_r = 17'h1FFF8 + AW'($urandom_range(0, 7));
        default: a_r = AW'($urandom);
      endcase
      wd_r = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      model_op(we_r, f3_r, a_r, wd_r, e_rd, e_err, e_lat, e_nwe, e_wd);
      issue(we_r, f3_r, a_r, wd_r, rd, err, lat, nwe, mwd, waited);
      chk($sformatf("rand%0d latency", k), 32'(lat), 32'(e_lat));
      chk($sformatf("rand%0d rdata", k), rd, e_rd);
      chk($sformatf("rand%0d err", k), 32'(err), 32'(e_err));
      chk($sformatf("rand%0d mem_we cycles", k), 32'(nwe), 32'(e_nwe));
      if (e_nwe > 0) chk($sformatf("rand%0d mem_wd", k), mwd, e_wd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
